serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder. Sits directly upstream of the half-adder cells and feeds them.
//   - Captures two operands on START.
//   - Presents one bit pair per clock, LSB first, to a full-adder cell built from two half adders.
//   - Registers the carry between bits.
//   - Shifts the sum bits into a result register and pulses DONE when the word is complete.

---
 rtl/serial_adder_pkg.sv | 25 ++
 rtl/serial_fa_cell.sv | 30 +++
 rtl/serial_ha_cell.sv | 12 +
 rtl/serial_adder.sv | 125 ++++++++++++
 tb/tb_serial_adder.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Bits needed to index 0..val-1 (val >= 2).
    function automatic int unsigned clog2(input int unsigned val);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << r) < val) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full adder built from two half adders plus an OR for the carry.
module serial_fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    serial_ha_cell u_ha0 (
        .i_x (i_a),
        .i_y (i_b),
        .o_s (w_s1),
        .o_c (w_c1)
    );

    serial_ha_cell u_ha1 (
        .i_x (w_s1),
        .i_y (i_c),
        .o_s (o_s),
        .o_c (w_c2)
    );

    assign o_c = w_c1 | w_c2;

endmodule

// File: rtl/serial_ha_cell.sv
// Half adder: sum and carry of two input bits.
module serial_ha_cell (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the i_sub port (A-B via inverted B and carry-in 1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int unsigned CNT_W = clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               w_accept;
    logic               w_last;
    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_cin;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = i_sub ? ~i_b : i_b;
    assign w_cin    = i_sub;
`else
    assign w_b_load = i_b;
    assign w_cin    = 1'b0;
`endif

    serial_fa_cell u_fa (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                // START is deliberately not looked at here.
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = FIN;
                end
            end
            FIN: begin
                o_done = 1'b1;
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= w_b_load;
            r_carry <= w_cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_carry <= w_c;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_cout <= w_c;
            end
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); SERIAL_ADDER_SUB_EN adds subtract vectors.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             sub;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks;
    int n_errors;
    int done_cnt;
    int done_base;

    serial_adder #(
        .WIDTH (WIDTH)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
`ifdef SERIAL_ADDER_SUB_EN
        .i_sub   (sub),
`endif
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full operation from IDLE: accept, WIDTH RUN cycles, FIN, then back to IDLE.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vsub, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        a     = va;
        b     = vb;
        sub   = vsub;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = '1;
        b     = '1;
        for (int k = 0; k < int'(WIDTH); k++) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " done early"}, 32'(done), 32'd0);
            step();
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy fin"}, 32'(busy), 32'd0);
        chk({tag, " sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, " cout"}, 32'(cout), 32'(exp_cout));
        step();
        chk({tag, " done pulse"}, 32'(done), 32'd0);
        chk({tag, " sum held"}, 32'(sum), 32'(exp_sum));
        chk({tag, " cout held"}, 32'(cout), 32'(exp_cout));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        rst      = 1'b1;
        sub      = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        step();
        step();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        rst = 1'b0;
        step();

        run_op("0f+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        run_op("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("aa+55", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);

        // START during RUN must be ignored.
        done_base = done_cnt;
        a = 8'h03; b = 8'h04; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        a = 8'hF0; b = 8'hF0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("ign done", 32'(done), 32'd1);
        chk("ign sum", 32'(sum), 32'h07);
        chk("ign cout", 32'(cout), 32'd0);
        repeat (3) step();
        chk("ign busy idle", 32'(busy), 32'd0);
        chk("ign one done", 32'(done_cnt - done_base), 32'd1);

        // Back-to-back: START held high into FIN.
        a = 8'h0F; b = 8'h01; start = 1'b1;
        step();
        a = 8'h80; b = 8'h80;
        repeat (8) step();
        chk("b2b first done", 32'(done), 32'd1);
        chk("b2b first sum", 32'(sum), 32'h10);
        step();
        start = 1'b0;
        chk("b2b restart busy", 32'(busy), 32'd1);
        chk("b2b restart done", 32'(done), 32'd0);
        repeat (8) step();
        chk("b2b second done", 32'(done), 32'd1);
        chk("b2b second sum", 32'(sum), 32'h00);
        chk("b2b second cout", 32'(cout), 32'd1);
        step();

        // Asynchronous reset mid-RUN.
        done_base = done_cnt;
        a = 8'h55; b = 8'h33; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("rst partial sum", 32'(sum), 32'h80);
        chk("rst pre busy", 32'(busy), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst cout", 32'(cout), 32'd0);
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("rst no done", 32'(done_cnt - done_base), 32'd0);
        chk("rst idle busy", 32'(busy), 32'd0);
        run_op("01+01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op("05-07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
        run_op("07-05", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
        run_op("sub0 add", 8'h07, 8'h05, 1'b0, 8'h0C, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
